// File: rtl/mem_fill_ram.sv
// Single-clock RAM with a hardware fill engine that writes a programmable pattern
// over an inclusive address range (ascending or descending), plus a user port.
module mem_fill_ram #(
  parameter int              DATA_W    = 8,
  parameter int              DEPTH     = 1024,
  parameter int              ADDR_W    = 10,
  parameter int              RD_LAT    = 1,
  parameter int              AUTO_INIT = 1,
  parameter int              PATTERN   = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start,
  input  logic [ADDR_W-1:0] init_lo,
  input  logic [ADDR_W-1:0] init_hi,
  output logic              init_busy,
  output logic              init_done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              access_err
);

  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state_reg;
  logic                auto_pend_reg;
  logic [ADDR_W-1:0]   ptr_reg;
  logic [ADDR_W-1:0]   hi_reg;
  logic                down_reg;
  logic [DATA_W-1:0]   k_reg;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                range_ok;
  logic                start_ok;
  logic                start_bad;
  logic                user_bad;
  logic                wr_ok;
  logic                rd_ok;
  logic                rd_oor;
  logic [DATA_W-1:0]   fill_word;

  always_comb begin
    range_ok  = ({1'b0, init_lo} < DEPTH_A) && ({1'b0, init_hi} < DEPTH_A);
    start_ok  = (state_reg == IDLE) && !auto_pend_reg && init_start && range_ok;
    start_bad = (state_reg == IDLE) && !auto_pend_reg && init_start && !range_ok;
    user_bad  = (state_reg == FILL) && (wr_en || rd_en);
    wr_ok     = (state_reg == IDLE) && wr_en && ({1'b0, wr_addr} < DEPTH_A);
    rd_ok     = (state_reg == IDLE) && rd_en;
    rd_oor    = ({1'b0, rd_addr} >= DEPTH_A);
    case (PATTERN)
      1:       fill_word = DATA_W'(ptr_reg);
      2:       fill_word = INIT_VAL + k_reg;
      default: fill_word = INIT_VAL;
    endcase
  end

  // The auto-init request is held as a pending flag so it fires on the first
  // edge after reset release and takes priority over any user fill request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      auto_pend_reg <= (AUTO_INIT != 0);
      ptr_reg       <= '0;
      hi_reg        <= '0;
      down_reg      <= 1'b0;
      k_reg         <= '0;
      init_busy     <= 1'b0;
      init_done     <= 1'b0;
      access_err    <= 1'b0;
    end else begin
      init_done  <= 1'b0;
      access_err <= start_bad || user_bad;
      case (state_reg)
        IDLE: begin
          if (auto_pend_reg) begin
            auto_pend_reg <= 1'b0;
            ptr_reg       <= '0;
            hi_reg        <= LAST_A;
            down_reg      <= 1'b0;
            k_reg         <= '0;
            init_busy     <= 1'b1;
            state_reg     <= FILL;
          end else if (start_ok) begin
            ptr_reg   <= init_lo;
            hi_reg    <= init_hi;
            down_reg  <= (init_lo > init_hi);
            k_reg     <= '0;
            init_busy <= 1'b1;
            state_reg <= FILL;
          end
        end
        FILL: begin
          k_reg <= k_reg + 1'b1;
          if (ptr_reg == hi_reg) begin
            init_busy <= 1'b0;
            init_done <= 1'b1;
            state_reg <= IDLE;
          end else if (down_reg) begin
            ptr_reg <= ptr_reg - 1'b1;
          end else begin
            ptr_reg <= ptr_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Array write port: the fill engine owns it during FILL, the user otherwise.
  always_ff @(posedge clk) begin
    if (state_reg == FILL) begin
      mem[ptr_reg] <= fill_word;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read pipeline; stage 0 is the registered array read (read-first), later
  // stages only add latency. Data in each stage holds when its valid is low.
  logic              v_pipe [RD_LAT];
  logic              e_pipe [RD_LAT];
  logic [DATA_W-1:0] d_pipe [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe[0] <= 1'b0;
      e_pipe[0] <= 1'b0;
      d_pipe[0] <= '0;
    end else begin
      v_pipe[0] <= rd_ok;
      e_pipe[0] <= rd_ok && rd_oor;
      if (rd_ok) begin
        d_pipe[0] <= rd_oor ? '0 : mem[rd_addr];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_pipe[gi] <= 1'b0;
          e_pipe[gi] <= 1'b0;
          d_pipe[gi] <= '0;
        end else begin
          v_pipe[gi] <= v_pipe[gi-1];
          e_pipe[gi] <= e_pipe[gi-1];
          if (v_pipe[gi-1]) begin
            d_pipe[gi] <= d_pipe[gi-1];
          end
        end
      end
    end
  endgenerate

  assign rd_valid = v_pipe[RD_LAT-1];
  assign rd_err   = e_pipe[RD_LAT-1];
  assign rd_data  = d_pipe[RD_LAT-1];

endmodule

// File: tb/tb_mem_fill_ram.sv
// Directed bench for mem_fill_ram: three instances cover auto-init, pattern
// fills with RD_LAT=2, fill-time collisions, async reset mid-fill and bounds.
module tb_mem_fill_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: DEPTH=16, ADDR_W=5, PATTERN=1, auto-init, RD_LAT=1
  logic       a_rst, a_init_start, a_init_busy, a_init_done, a_wr_en, a_rd_en;
  logic       a_rd_valid, a_rd_err, a_access_err;
  logic [4:0] a_init_lo, a_init_hi, a_wr_addr, a_rd_addr;
  logic [7:0] a_wr_data, a_rd_data;
  // B: DEPTH=16, ADDR_W=4, PATTERN=2, INIT_VAL=F0, no auto-init, RD_LAT=2
  logic       b_rst, b_init_start, b_init_busy, b_init_done, b_wr_en, b_rd_en;
  logic       b_rd_valid, b_rd_err, b_access_err;
  logic [3:0] b_init_lo, b_init_hi, b_wr_addr, b_rd_addr;
  logic [7:0] b_wr_data, b_rd_data;
  // C: DEPTH=12, ADDR_W=4, PATTERN=0, INIT_VAL=3C, auto-init, RD_LAT=1
  logic       c_rst, c_init_start, c_init_busy, c_init_done, c_wr_en, c_rd_en;
  logic       c_rd_valid, c_rd_err, c_access_err;
  logic [3:0] c_init_lo, c_init_hi, c_wr_addr, c_rd_addr;
  logic [7:0] c_wr_data, c_rd_data;

  mem_fill_ram #(.DATA_W(8), .DEPTH(16), .ADDR_W(5), .RD_LAT(1), .AUTO_INIT(1),
                 .PATTERN(1), .INIT_VAL(8'h00)) u_a (
    .clk(clk), .rst(a_rst), .init_start(a_init_start), .init_lo(a_init_lo),
    .init_hi(a_init_hi), .init_busy(a_init_busy), .init_done(a_init_done),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .rd_en(a_rd_en),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .rd_err(a_rd_err), .access_err(a_access_err));

  mem_fill_ram #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .RD_LAT(2), .AUTO_INIT(0),
                 .PATTERN(2), .INIT_VAL(8'hF0)) u_b (
    .clk(clk), .rst(b_rst), .init_start(b_init_start), .init_lo(b_init_lo),
    .init_hi(b_init_hi), .init_busy(b_init_busy), .init_done(b_init_done),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .rd_en(b_rd_en),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .rd_err(b_rd_err), .access_err(b_access_err));

  mem_fill_ram #(.DATA_W(8), .DEPTH(12), .ADDR_W(4), .RD_LAT(1), .AUTO_INIT(1),
                 .PATTERN(0), .INIT_VAL(8'h3C)) u_c (
    .clk(clk), .rst(c_rst), .init_start(c_init_start), .init_lo(c_init_lo),
    .init_hi(c_init_hi), .init_busy(c_init_busy), .init_done(c_init_done),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .rd_en(c_rd_en),
    .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_valid(c_rd_valid),
    .rd_err(c_rd_err), .access_err(c_access_err));

  typedef struct {
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                              input logic re, input logic [4:0] ra,
                              input logic ev, input logic [7:0] ed, input logic ee);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.rd_en = re; v.rd_addr = ra;
    v.exp_valid = ev; v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Apply each row for one edge, then compare the outputs seen after that edge.
  task automatic run_tab(input bit on_b, input string tag);
    for (int i = 0; i < tab.size(); i++) begin
      if (on_b) begin
        b_wr_en = tab[i].wr_en; b_wr_addr = tab[i].wr_addr[3:0]; b_wr_data = tab[i].wr_data;
        b_rd_en = tab[i].rd_en; b_rd_addr = tab[i].rd_addr[3:0];
      end else begin
        a_wr_en = tab[i].wr_en; a_wr_addr = tab[i].wr_addr; a_wr_data = tab[i].wr_data;
        a_rd_en = tab[i].rd_en; a_rd_addr = tab[i].rd_addr;
      end
      tick;
      chk($sformatf("%s[%0d].valid", tag, i), on_b ? b_rd_valid : a_rd_valid, tab[i].exp_valid);
      chk($sformatf("%s[%0d].data", tag, i), on_b ? b_rd_data : a_rd_data, tab[i].exp_data);
      chk($sformatf("%s[%0d].err", tag, i), on_b ? b_rd_err : a_rd_err, tab[i].exp_err);
      chk($sformatf("%s[%0d].aerr", tag, i), on_b ? b_access_err : a_access_err, 0);
    end
    a_wr_en = 0; a_rd_en = 0; b_wr_en = 0; b_rd_en = 0;
    tab.delete();
  endtask

  task automatic b_fill(input logic [3:0] lo, input logic [3:0] hi,
                        output int nbusy, output int ndone);
    b_init_start = 1; b_init_lo = lo; b_init_hi = hi;
    tick;
    b_init_start = 0;
    nbusy = b_init_busy ? 1 : 0;
    ndone = 0;
    for (int j = 0; j < 40; j++) begin
      tick;
      if (b_init_busy) nbusy++;
      if (b_init_done) begin
        ndone++;
        break;
      end
    end
  endtask

  initial begin
    int nb, nd, ab, ad, cb, cd, aerr_n, val_n;
    a_rst = 1; b_rst = 1; c_rst = 1;
    a_init_start = 0; a_init_lo = 0; a_init_hi = 0; a_wr_en = 0; a_wr_addr = 0;
    a_wr_data = 0; a_rd_en = 0; a_rd_addr = 0;
    b_init_start = 0; b_init_lo = 0; b_init_hi = 0; b_wr_en = 0; b_wr_addr = 0;
    b_wr_data = 0; b_rd_en = 0; b_rd_addr = 0;
    c_init_start = 0; c_init_lo = 0; c_init_hi = 0; c_wr_en = 0; c_wr_addr = 0;
    c_wr_data = 0; c_rd_en = 0; c_rd_addr = 0;
    tick; tick;

    chk("rst.a_busy", a_init_busy, 0);
    chk("rst.a_done", a_init_done, 0);
    chk("rst.a_valid", a_rd_valid, 0);
    chk("rst.a_data", a_rd_data, 0);
    chk("rst.b_aerr", b_access_err, 0);
    chk("rst.c_busy", c_init_busy, 0);

    // Auto-init on A (16 words) and C (12 words)
    a_rst = 0; b_rst = 0; c_rst = 0;
    tick;
    chk("auto.a_busy_E0", a_init_busy, 1);
    chk("auto.a_aerr_E0", a_access_err, 0);
    ab = 1; ad = 0; cb = c_init_busy ? 1 : 0; cd = 0;
    for (int j = 0; j < 30; j++) begin
      tick;
      if (a_init_busy) ab++;
      if (a_init_done) ad++;
      if (c_init_busy) cb++;
      if (c_init_done) cd++;
    end
    chk("auto.a_busy_cycles", ab, 16);
    chk("auto.a_done_pulses", ad, 1);
    chk("auto.c_busy_cycles", cb, 12);
    chk("auto.c_done_pulses", cd, 1);

    // A: address pattern readback, out-of-range read, writes
    for (int i = 0; i < 16; i++) tab.push_back(mk(0, 0, 0, 1, 5'(i), 1, 8'(i), 0));
    tab.push_back(mk(0, 0, 0, 1, 20, 1, 8'h00, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0));
    tab.push_back(mk(0, 0, 0, 1, 15, 1, 8'h0F, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 8'h0F, 0));
    tab.push_back(mk(1, 5, 8'h99, 0, 0, 0, 8'h0F, 0));
    tab.push_back(mk(1, 20, 8'hEE, 0, 0, 0, 8'h0F, 0));
    tab.push_back(mk(0, 0, 0, 1, 5, 1, 8'h99, 0));
    tab.push_back(mk(0, 0, 0, 1, 4, 1, 8'h04, 0));
    run_tab(0, "a");

    // B: full ascending fill, then back-to-back descending fill 12..9
    b_fill(0, 15, nb, nd);
    chk("b.fill0_15_busy", nb, 16);
    chk("b.fill0_15_done", nd, 1);
    b_fill(12, 9, nb, nd);
    chk("b.fill12_9_busy", nb, 4);
    chk("b.fill12_9_done", nd, 1);
    tick;
    chk("b.done_one_cycle", b_init_done, 0);

    // B: RD_LAT=2 readback, writes, same-cycle read-first
    tab.push_back(mk(0, 0, 0, 1, 8, 0, 8'h00, 0));
    tab.push_back(mk(0, 0, 0, 1, 9, 1, 8'hF8, 0));
    tab.push_back(mk(0, 0, 0, 1, 10, 1, 8'hF3, 0));
    tab.push_back(mk(0, 0, 0, 1, 11, 1, 8'hF2, 0));
    tab.push_back(mk(0, 0, 0, 1, 12, 1, 8'hF1, 0));
    tab.push_back(mk(0, 0, 0, 1, 13, 1, 8'hF0, 0));
    tab.push_back(mk(1, 3, 8'hA5, 0, 0, 1, 8'hFD, 0));
    tab.push_back(mk(1, 4, 8'h5A, 0, 0, 0, 8'hFD, 0));
    tab.push_back(mk(0, 0, 0, 1, 3, 0, 8'hFD, 0));
    tab.push_back(mk(0, 0, 0, 1, 4, 1, 8'hA5, 0));
    tab.push_back(mk(1, 3, 8'h77, 1, 3, 1, 8'h5A, 0));
    tab.push_back(mk(0, 0, 0, 1, 3, 1, 8'hA5, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 8'h77, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 8'h77, 0));
    run_tab(1, "b1");

    // B: user access and a redundant init_start during a 10-word fill
    b_init_start = 1; b_init_lo = 0; b_init_hi = 9;
    tick;
    b_init_start = 0;
    nb = b_init_busy ? 1 : 0; nd = 0; aerr_n = 0; val_n = 0;
    for (int j = 0; j < 14; j++) begin
      b_wr_en = (j == 2); b_wr_addr = 2; b_wr_data = 8'h11;
      b_rd_en = (j == 3); b_rd_addr = 2;
      b_init_start = (j == 4); b_init_hi = 15;
      tick;
      if (b_init_busy) nb++;
      if (b_init_done) nd++;
      if (b_access_err) aerr_n++;
      if (b_rd_valid) val_n++;
    end
    b_wr_en = 0; b_rd_en = 0; b_init_start = 0;
    chk("coll.busy_cycles", nb, 10);
    chk("coll.done_pulses", nd, 1);
    chk("coll.aerr_pulses", aerr_n, 2);
    chk("coll.valid_count", val_n, 0);

    tab.push_back(mk(0, 0, 0, 1, 2, 0, 8'h77, 0));
    tab.push_back(mk(0, 0, 0, 1, 3, 1, 8'hF2, 0));
    tab.push_back(mk(0, 0, 0, 1, 9, 1, 8'hF3, 0));
    tab.push_back(mk(0, 0, 0, 1, 10, 1, 8'hF9, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 8'hF2, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 8'hF2, 0));
    run_tab(1, "b2");

    // B: async reset after 5 words of a descending 9..0 fill
    b_init_start = 1; b_init_lo = 9; b_init_hi = 0;
    tick;
    b_init_start = 0;
    repeat (5) tick;
    chk("rstfill.busy_before", b_init_busy, 1);
    #2 b_rst = 1;
    #1 chk("rstfill.busy_async", b_init_busy, 0);
    nd = 0;
    repeat (3) begin
      tick;
      if (b_init_done) nd++;
    end
    b_rst = 0;
    repeat (2) begin
      tick;
      if (b_init_done) nd++;
    end
    chk("rstfill.no_done", nd, 0);
    chk("rstfill.busy_after", b_init_busy, 0);

    tab.push_back(mk(0, 0, 0, 1, 9, 0, 8'h00, 0));
    tab.push_back(mk(0, 0, 0, 1, 5, 1, 8'hF0, 0));
    tab.push_back(mk(0, 0, 0, 1, 4, 1, 8'hF4, 0));
    tab.push_back(mk(0, 0, 0, 1, 6, 1, 8'hF4, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 8'hF3, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 8'hF3, 0));
    run_tab(1, "b3");

    // C: out-of-range bounds and reads with DEPTH=12
    c_init_start = 1; c_init_lo = 0; c_init_hi = 12;
    tick;
    c_init_start = 0;
    chk("c.hi12_aerr", c_access_err, 1);
    chk("c.hi12_busy", c_init_busy, 0);
    tick;
    chk("c.aerr_pulse_end", c_access_err, 0);
    chk("c.still_idle", c_init_busy, 0);
    c_init_start = 1; c_init_lo = 12; c_init_hi = 0;
    tick;
    c_init_start = 0;
    chk("c.lo12_aerr", c_access_err, 1);
    c_rd_en = 1; c_rd_addr = 14;
    tick;
    chk("c.rd14_valid", c_rd_valid, 1);
    chk("c.rd14_err", c_rd_err, 1);
    chk("c.rd14_data", c_rd_data, 8'h00);
    chk("c.rd14_aerr", c_access_err, 0);
    c_rd_addr = 11;
    tick;
    chk("c.rd11_data", c_rd_data, 8'h3C);
    chk("c.rd11_err", c_rd_err, 0);
    c_rd_en = 0;
    c_init_start = 1; c_init_lo = 2; c_init_hi = 3;
    tick;
    c_init_start = 0;
    chk("c.fill_ok_busy", c_init_busy, 1);
    chk("c.fill_ok_aerr", c_access_err, 0);
    repeat (3) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
